// File: rtl/sb_path_sequencer.sv
// sb_path_sequencer: path-level controller between the line decoder and the
// motor driver. Confirms nodes from the decoder's turn code and executes the
// next manoeuvre (straight/left/right/halt) from a loaded path list.
// Optional build macro: SB_SEQ_TIMEOUT_EN enables the TURN watchdog (-> FAULT).
module sb_path_sequencer #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned NODE_DEBOUNCE = 4,
    parameter int unsigned CROSS_CYCLES  = 5_000_000,
    parameter int unsigned TURN_MIN      = 10_000_000,
    parameter int unsigned TURN_TIMEOUT  = 100_000_000
) (
    input  logic                     clk_50,
    input  logic                     rst_n,
    input  logic [2:0]               line_cmd,
    input  logic                     path_wr_valid,
    output logic                     path_wr_ready,
    input  logic [1:0]               path_wr_data,
    input  logic                     path_clear,
    input  logic                     start,
    input  logic                     abort,
    output logic [2:0]               motor_cmd,
    output logic                     busy,
    output logic                     done,
    output logic                     fault,
    output logic [7:0]               node_count,
    output logic [$clog2(DEPTH):0]   path_count
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned DW     = $clog2(NODE_DEBOUNCE + 1);
    localparam int unsigned TMAX_A = (CROSS_CYCLES > TURN_MIN) ? CROSS_CYCLES : TURN_MIN;
    localparam int unsigned TMAX   = (TMAX_A > TURN_TIMEOUT) ? TMAX_A : TURN_TIMEOUT;
    localparam int unsigned TW     = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DEB_LIM   = DW'(NODE_DEBOUNCE);
    localparam logic [TW-1:0] CROSS_LIM = TW'(CROSS_CYCLES);
    localparam logic [TW-1:0] TURN_LIM  = TW'(TURN_MIN);
`ifdef SB_SEQ_TIMEOUT_EN
    localparam logic [TW-1:0] TOUT_LIM  = TW'(TURN_TIMEOUT);
`endif

    localparam logic [2:0] CMD_STOP  = 3'b000;
    localparam logic [2:0] CMD_FWD   = 3'b001;
    localparam logic [2:0] CMD_LEFT  = 3'b010;
    localparam logic [2:0] CMD_RIGHT = 3'b011;

    localparam logic [1:0] ENT_STRAIGHT = 2'b00;
    localparam logic [1:0] ENT_RIGHT    = 2'b10;
    localparam logic [1:0] ENT_HALT     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FOLLOW, S_CROSS, S_TURN, S_DONE, S_FAULT
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]  path_count_nxt;
    logic [7:0]     node_count_nxt;
    logic [DW-1:0]  deb_cnt, deb_cnt_nxt;
    logic [TW-1:0]  tmr, tmr_nxt, tmr_inc;
    logic [1:0]     entry, entry_nxt;
    logic [1:0]     head;
    logic           line_fwd;
    logic           wr_fire;
    logic [2:0]     motor_nxt;
    logic           busy_nxt, done_nxt;
`ifdef SB_SEQ_TIMEOUT_EN
    logic           fault_nxt;
`endif

    logic [1:0] path_mem [DEPTH];

    assign path_wr_ready = (state == S_IDLE) && (path_count < CW'(DEPTH));
    assign wr_fire       = path_wr_valid && path_wr_ready && !path_clear;
    assign head          = path_mem[rd_ptr[AW-1:0]];
    // undefined decoder codes (1xx) count as forward, including for reacquisition
    assign line_fwd      = (line_cmd == CMD_FWD) || line_cmd[2];
    assign tmr_inc       = tmr + TW'(1);

    // path list storage; contents survive runs, path_count defines validity
    always_ff @(posedge clk_50) begin
        if (wr_fire) begin
            path_mem[path_count[AW-1:0]] <= path_wr_data;
        end
    end

    // state register plus registered outputs and datapath
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            path_count <= '0;
            node_count <= '0;
            deb_cnt    <= '0;
            tmr        <= '0;
            entry      <= '0;
            motor_cmd  <= CMD_STOP;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_ptr     <= rd_ptr_nxt;
            path_count <= path_count_nxt;
            node_count <= node_count_nxt;
            deb_cnt    <= deb_cnt_nxt;
            tmr        <= tmr_nxt;
            entry      <= entry_nxt;
            motor_cmd  <= motor_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

`ifdef SB_SEQ_TIMEOUT_EN
    // fault flag register (watchdog build only)
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else begin
            fault <= fault_nxt;
        end
    end
`else
    assign fault = 1'b0;
`endif

    // next-state and datapath updates; abort overrides every transition
    always_comb begin
        state_nxt      = state;
        rd_ptr_nxt     = rd_ptr;
        node_count_nxt = node_count;
        deb_cnt_nxt    = '0;
        tmr_nxt        = '0;
        entry_nxt      = entry;
        path_count_nxt = path_count;

        if (state == S_IDLE) begin
            if (path_clear) begin
                path_count_nxt = '0;
            end else if (wr_fire) begin
                path_count_nxt = path_count + CW'(1);
            end
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (start && (path_count != '0)) begin
                    state_nxt      = S_FOLLOW;
                    rd_ptr_nxt     = '0;
                    node_count_nxt = '0;
                end
            end
            S_FOLLOW: begin
                if (line_cmd == CMD_STOP) begin
                    if (deb_cnt + DW'(1) == DEB_LIM) begin
                        // node confirmed: count it and dispatch on this same edge
                        if (node_count != 8'hFF) begin
                            node_count_nxt = node_count + 8'd1;
                        end
                        if ((rd_ptr == path_count) || (head == ENT_HALT)) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt  = S_CROSS;
                            rd_ptr_nxt = rd_ptr + CW'(1);
                            entry_nxt  = head;
                        end
                    end else begin
                        deb_cnt_nxt = deb_cnt + DW'(1);
                    end
                end
            end
            S_CROSS: begin
                if (tmr_inc == CROSS_LIM) begin
                    state_nxt = (entry == ENT_STRAIGHT) ? S_FOLLOW : S_TURN;
                end else begin
                    tmr_nxt = tmr_inc;
                end
            end
            S_TURN: begin
                if ((tmr_inc >= TURN_LIM) && line_fwd) begin
                    state_nxt = S_FOLLOW;
`ifdef SB_SEQ_TIMEOUT_EN
                end else if (tmr_inc >= TOUT_LIM) begin
                    state_nxt = S_FAULT;
                end else begin
                    tmr_nxt = tmr_inc;
                end
`else
                end else begin
                    // saturate once the minimum is met; TURN may wait indefinitely
                    tmr_nxt = (tmr_inc >= TURN_LIM) ? TURN_LIM : tmr_inc;
                end
`endif
            end
            default: begin
                state_nxt = state;
            end
        endcase

        if (abort) begin
            state_nxt      = S_IDLE;
            rd_ptr_nxt     = rd_ptr;
            node_count_nxt = node_count;
            deb_cnt_nxt    = '0;
            tmr_nxt        = '0;
            entry_nxt      = entry;
        end
    end

    // output decode from the upcoming state so outputs change with the state
    always_comb begin
        motor_nxt = CMD_STOP;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
`ifdef SB_SEQ_TIMEOUT_EN
        fault_nxt = 1'b0;
`endif
        case (state_nxt)
            S_FOLLOW: begin
                motor_nxt = ((line_cmd == CMD_LEFT) || (line_cmd == CMD_RIGHT)) ? line_cmd : CMD_FWD;
                busy_nxt  = 1'b1;
            end
            S_CROSS: begin
                motor_nxt = CMD_FWD;
                busy_nxt  = 1'b1;
            end
            S_TURN: begin
                motor_nxt = (entry_nxt == ENT_RIGHT) ? CMD_RIGHT : CMD_LEFT;
                busy_nxt  = 1'b1;
            end
            S_DONE: begin
                done_nxt = 1'b1;
            end
`ifdef SB_SEQ_TIMEOUT_EN
            S_FAULT: begin
                fault_nxt = 1'b1;
            end
`endif
            default: begin
                motor_nxt = CMD_STOP;
            end
        endcase
    end

endmodule

// File: tb/tb_sb_path_sequencer.sv
// Scoreboard bench for sb_path_sequencer (DEPTH=4, DEBOUNCE=2, CROSS=3,
// TURN_MIN=4, TURN_TIMEOUT=8). Watchdog scenario runs only when
// SB_SEQ_TIMEOUT_EN is defined.
module tb_sb_path_sequencer;

    localparam logic [2:0] M_STOP  = 3'b000;
    localparam logic [2:0] M_FWD   = 3'b001;
    localparam logic [2:0] M_LEFT  = 3'b010;
    localparam logic [2:0] M_RIGHT = 3'b011;

    logic       clk_50 = 1'b0;
    logic       rst_n;
    logic [2:0] line_cmd;
    logic       path_wr_valid;
    logic       path_wr_ready;
    logic [1:0] path_wr_data;
    logic       path_clear;
    logic       start;
    logic       abort;
    logic [2:0] motor_cmd;
    logic       busy;
    logic       done;
    logic       fault;
    logic [7:0] node_count;
    logic [2:0] path_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        string      tag;
        logic [2:0] m;
        logic       b;
        logic       d;
        logic       f;
        logic [7:0] n;
        logic [2:0] pc;
        logic       r;
    } exp_t;

    exp_t sb[$];

    sb_path_sequencer #(
        .DEPTH         (4),
        .NODE_DEBOUNCE (2),
        .CROSS_CYCLES  (3),
        .TURN_MIN      (4),
        .TURN_TIMEOUT  (8)
    ) dut (
        .clk_50        (clk_50),
        .rst_n         (rst_n),
        .line_cmd      (line_cmd),
        .path_wr_valid (path_wr_valid),
        .path_wr_ready (path_wr_ready),
        .path_wr_data  (path_wr_data),
        .path_clear    (path_clear),
        .start         (start),
        .abort         (abort),
        .motor_cmd     (motor_cmd),
        .busy          (busy),
        .done          (done),
        .fault         (fault),
        .node_count    (node_count),
        .path_count    (path_count)
    );

    always #5 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pop one expectation per edge that has one queued, sampled after the edge
    always @(posedge clk_50) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".motor"}, 32'(motor_cmd),     32'(e.m));
            chk({e.tag, ".busy"},  32'(busy),          32'(e.b));
            chk({e.tag, ".done"},  32'(done),          32'(e.d));
            chk({e.tag, ".fault"}, 32'(fault),         32'(e.f));
            chk({e.tag, ".nodes"}, 32'(node_count),    32'(e.n));
            chk({e.tag, ".pcnt"},  32'(path_count),    32'(e.pc));
            chk({e.tag, ".ready"}, 32'(path_wr_ready), 32'(e.r));
        end
    end

    // queue the expected post-edge outputs for the inputs set now, then advance one cycle
    task automatic tick(input string tag, input logic [2:0] m, input logic b, input logic d,
                        input logic f, input logic [7:0] n, input logic [2:0] pc, input logic r);
        exp_t e;
        e.tag = tag; e.m = m; e.b = b; e.d = d; e.f = f; e.n = n; e.pc = pc; e.r = r;
        sb.push_back(e);
        @(posedge clk_50);
        @(negedge clk_50);
    endtask

    logic [1:0] entries [4];

    initial begin
        entries[0] = 2'b01; entries[1] = 2'b10; entries[2] = 2'b00; entries[3] = 2'b11;
        rst_n = 1'b0; line_cmd = M_FWD; path_wr_valid = 1'b0; path_wr_data = 2'b00;
        path_clear = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk_50);
        tick("reset", M_STOP, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;
        tick("idle", M_STOP, 0, 0, 0, 0, 0, 1);

        // load the list, then overfill
        for (int i = 0; i < 4; i++) begin
            path_wr_valid = 1'b1; path_wr_data = entries[i];
            tick("load", M_STOP, 0, 0, 0, 0, 3'(i + 1), (i + 1) < 4);
        end
        for (int i = 0; i < 5; i++) begin
            path_wr_data = 2'b01;
            tick("load_full", M_STOP, 0, 0, 0, 0, 4, 0);
        end
        path_wr_valid = 1'b0;

        // run 1: start and follow passthrough
        start = 1'b1; line_cmd = M_FWD;
        tick("start", M_FWD, 1, 0, 0, 0, 4, 0);
        start = 1'b0;
        line_cmd = M_LEFT;  tick("pass_l", M_LEFT, 1, 0, 0, 0, 4, 0);
        line_cmd = M_RIGHT; tick("pass_r", M_RIGHT, 1, 0, 0, 0, 4, 0);
        line_cmd = 3'b111;  tick("pass_x", M_FWD, 1, 0, 0, 0, 4, 0);
        for (int i = 0; i < 3; i++) begin
            line_cmd = M_STOP; tick("glitch0", M_FWD, 1, 0, 0, 0, 4, 0);
            line_cmd = M_FWD;  tick("glitch1", M_FWD, 1, 0, 0, 0, 4, 0);
        end

        // node 1: entry 01 (left), early 001 during TURN must be ignored
        line_cmd = M_STOP;
        tick("n1_deb", M_FWD, 1, 0, 0, 0, 4, 0);
        tick("n1_conf", M_FWD, 1, 0, 0, 1, 4, 0);
        tick("n1_cross", M_FWD, 1, 0, 0, 1, 4, 0);
        tick("n1_cross", M_FWD, 1, 0, 0, 1, 4, 0);
        tick("n1_turn", M_LEFT, 1, 0, 0, 1, 4, 0);
        line_cmd = M_FWD;
        for (int i = 0; i < 3; i++) tick("n1_turn_min", M_LEFT, 1, 0, 0, 1, 4, 0);
        tick("n1_reacq", M_FWD, 1, 0, 0, 1, 4, 0);

        // node 2: entry 10 (right), reacquire late
        line_cmd = M_STOP;
        tick("n2_deb", M_FWD, 1, 0, 0, 1, 4, 0);
        tick("n2_conf", M_FWD, 1, 0, 0, 2, 4, 0);
        tick("n2_cross", M_FWD, 1, 0, 0, 2, 4, 0);
        tick("n2_cross", M_FWD, 1, 0, 0, 2, 4, 0);
        tick("n2_turn", M_RIGHT, 1, 0, 0, 2, 4, 0);
        line_cmd = M_LEFT;
        for (int i = 0; i < 5; i++) tick("n2_turn_wait", M_RIGHT, 1, 0, 0, 2, 4, 0);
        line_cmd = M_FWD;
        tick("n2_reacq", M_FWD, 1, 0, 0, 2, 4, 0);

        // node 3: entry 00 (straight) back to FOLLOW after the crossing
        line_cmd = M_STOP;
        tick("n3_deb", M_FWD, 1, 0, 0, 2, 4, 0);
        tick("n3_conf", M_FWD, 1, 0, 0, 3, 4, 0);
        tick("n3_cross", M_FWD, 1, 0, 0, 3, 4, 0);
        tick("n3_cross", M_FWD, 1, 0, 0, 3, 4, 0);
        line_cmd = M_RIGHT;
        tick("n3_follow", M_RIGHT, 1, 0, 0, 3, 4, 0);

        // node 4: entry 11 (halt)
        line_cmd = M_STOP;
        tick("n4_deb", M_FWD, 1, 0, 0, 3, 4, 0);
        tick("n4_halt", M_STOP, 0, 1, 0, 4, 4, 0);
        tick("done_hold", M_STOP, 0, 1, 0, 4, 4, 0);

        // restart from DONE replays entry 0 (left)
        start = 1'b1; line_cmd = M_FWD;
        tick("restart", M_FWD, 1, 0, 0, 0, 4, 0);
        start = 1'b0; line_cmd = M_STOP;
        tick("r_deb", M_FWD, 1, 0, 0, 0, 4, 0);
        tick("r_conf", M_FWD, 1, 0, 0, 1, 4, 0);
        tick("r_cross", M_FWD, 1, 0, 0, 1, 4, 0);
        tick("r_cross", M_FWD, 1, 0, 0, 1, 4, 0);
        tick("r_turn", M_LEFT, 1, 0, 0, 1, 4, 0);
        abort = 1'b1;
        tick("abort_turn", M_STOP, 0, 0, 0, 1, 4, 0);
        abort = 1'b0;

        // abort together with start during CROSS
        start = 1'b1; line_cmd = M_FWD;
        tick("a_start", M_FWD, 1, 0, 0, 0, 4, 0);
        start = 1'b0; line_cmd = M_STOP;
        tick("a_deb", M_FWD, 1, 0, 0, 0, 4, 0);
        tick("a_conf", M_FWD, 1, 0, 0, 1, 4, 0);
        abort = 1'b1; start = 1'b1;
        tick("abort_cross", M_STOP, 0, 0, 0, 1, 4, 0);
        abort = 1'b0; start = 1'b0;
        tick("idle_hold", M_STOP, 0, 0, 0, 1, 4, 0);

`ifdef SB_SEQ_TIMEOUT_EN
        // turn watchdog
        start = 1'b1; line_cmd = M_FWD;
        tick("t_start", M_FWD, 1, 0, 0, 0, 4, 0);
        start = 1'b0; line_cmd = M_STOP;
        tick("t_deb", M_FWD, 1, 0, 0, 0, 4, 0);
        tick("t_conf", M_FWD, 1, 0, 0, 1, 4, 0);
        tick("t_cross", M_FWD, 1, 0, 0, 1, 4, 0);
        tick("t_cross", M_FWD, 1, 0, 0, 1, 4, 0);
        tick("t_turn", M_LEFT, 1, 0, 0, 1, 4, 0);
        for (int i = 0; i < 7; i++) tick("t_turn_wait", M_LEFT, 1, 0, 0, 1, 4, 0);
        tick("timeout", M_STOP, 0, 0, 1, 1, 4, 0);
        start = 1'b1;
        tick("fault_hold", M_STOP, 0, 0, 1, 1, 4, 0);
        start = 1'b0; abort = 1'b1;
        tick("fault_abort", M_STOP, 0, 0, 0, 1, 4, 0);
        abort = 1'b0;
`endif

        // clear beats a simultaneous write; single straight entry ends on pointer==count
        path_clear = 1'b1; path_wr_valid = 1'b1; path_wr_data = 2'b00;
        tick("clear_wr", M_STOP, 0, 0, 0, 1, 0, 1);
        path_clear = 1'b0;
        tick("load1", M_STOP, 0, 0, 0, 1, 1, 1);
        path_wr_valid = 1'b0;
        start = 1'b1; line_cmd = M_FWD;
        tick("s_start", M_FWD, 1, 0, 0, 0, 1, 0);
        start = 1'b0; line_cmd = M_STOP;
        tick("s_deb", M_FWD, 1, 0, 0, 0, 1, 0);
        tick("s_conf", M_FWD, 1, 0, 0, 1, 1, 0);
        tick("s_cross", M_FWD, 1, 0, 0, 1, 1, 0);
        tick("s_cross", M_FWD, 1, 0, 0, 1, 1, 0);
        line_cmd = M_FWD;
        tick("s_follow", M_FWD, 1, 0, 0, 1, 1, 0);
        line_cmd = M_STOP;
        tick("s_deb2", M_FWD, 1, 0, 0, 1, 1, 0);
        tick("s_end", M_STOP, 0, 1, 0, 2, 1, 0);
        abort = 1'b1;
        tick("s_abort", M_STOP, 0, 0, 0, 2, 1, 1);
        abort = 1'b0; path_clear = 1'b1;
        tick("clear", M_STOP, 0, 0, 0, 2, 0, 1);
        path_clear = 1'b0; start = 1'b1; line_cmd = M_FWD;
        tick("start_empty", M_STOP, 0, 0, 0, 2, 0, 1);
        start = 1'b0;

        // reset mid-run drops the list
        path_wr_valid = 1'b1; path_wr_data = 2'b01;
        tick("m_load", M_STOP, 0, 0, 0, 2, 1, 1);
        path_wr_valid = 1'b0; start = 1'b1;
        tick("m_start", M_FWD, 1, 0, 0, 0, 1, 0);
        start = 1'b0; rst_n = 1'b0;
        tick("rst_mid", M_STOP, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
